// File: rtl/alu_divider_pkg.sv
// -----------------------------------------------------------------------------
// alu_divider_pkg
// Shared definitions for the iterative divider that sits beside the ALU in the
// execute stage.
//   div_state_t      : divider control states (IDLE, ITER, FIX)
//   DEF_WORD_WIDTH   : default operand/result width
//   div_cnt_width()  : width of the step counter for a given operand width
// -----------------------------------------------------------------------------
package alu_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int DEF_WORD_WIDTH = 8;

  // The counter must hold the value word_width itself, hence the +1.
  function automatic int div_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/alu_divider_div_step.sv
// -----------------------------------------------------------------------------
// alu_divider_div_step
// One combinational restoring-division step.
//   rem          : partial remainder before the step (always < divisor)
//   dividend_msb : bit shifted into the partial remainder this step
//   divisor      : divisor magnitude
//   rem_next     : partial remainder after the step
//   q_bit        : quotient bit produced by this step
// -----------------------------------------------------------------------------
module alu_divider_div_step #(
  parameter int word_width = 8
) (
  input  logic [word_width-1:0] rem,
  input  logic                  dividend_msb,
  input  logic [word_width-1:0] divisor,
  output logic [word_width-1:0] rem_next,
  output logic                  q_bit
);

  logic [word_width:0] shifted;
  logic [word_width:0] trial;

  assign shifted = {rem, dividend_msb};
  assign trial   = shifted - {1'b0, divisor};

  // Because rem < divisor, shifted < 2*divisor. When shifted's top bit is set
  // the subtraction cannot go negative, and its true result (< divisor) fits
  // in word_width bits, so trial's top bit is then a clean sign bit otherwise.
  assign q_bit    = shifted[word_width] | ~trial[word_width];
  assign rem_next = q_bit ? trial[word_width-1:0] : shifted[word_width-1:0];

endmodule

// File: rtl/alu_divider.sv
// -----------------------------------------------------------------------------
// alu_divider
// Multi-cycle restoring integer divider, signed or unsigned, one quotient bit
// per clock. The control unit pulses START, waits while BUSY, and takes Q/REM/
// DZF when DONE pulses.
//   CLK    : rising-edge clock
//   RST_N  : asynchronous active-low reset
//   START  : request a division (accepted only when idle)
//   SIGNED : 1 = two's-complement operands, sampled at accept
//   A, B   : dividend and divisor, sampled at accept
//   BUSY   : operation in progress
//   DONE   : one-cycle pulse, Q/REM/DZF just updated
//   Q, REM : quotient and remainder, held until the next completion
//   DZF    : divide-by-zero flag of the last completed operation
// -----------------------------------------------------------------------------
module alu_divider
  import alu_divider_pkg::*;
#(
  parameter int word_width = DEF_WORD_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  SIGNED,
  input  logic [word_width-1:0] A,
  input  logic [word_width-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [word_width-1:0] Q,
  output logic [word_width-1:0] REM,
  output logic                  DZF
);

  localparam int CW = div_cnt_width(word_width);

  div_state_t            state;
  logic [CW-1:0]         count;
  logic                  sgn_op;
  logic                  sign_a;
  logic                  sign_b;
  logic                  dz;
  logic [word_width-1:0] rem;
  logic [word_width-1:0] dividend;
  logic [word_width-1:0] divisor;
  logic [word_width-1:0] a_orig;

  logic [word_width-1:0] a_mag;
  logic [word_width-1:0] b_mag;
  logic [word_width-1:0] rem_next;
  logic                  q_bit;
  logic                  neg_q;
  logic                  neg_r;
  logic [word_width-1:0] q_fix;
  logic [word_width-1:0] rem_fix;

  // Two's-complement negate when neg is set. The most negative value maps to
  // itself, which is exactly its unsigned magnitude.
  function automatic logic [word_width-1:0] cond_negate(
    input logic [word_width-1:0] v,
    input logic                  neg
  );
    return neg ? ('0 - v) : v;
  endfunction

  assign a_mag = cond_negate(A, SIGNED & A[word_width-1]);
  assign b_mag = cond_negate(B, SIGNED & B[word_width-1]);

  alu_divider_div_step #(
    .word_width(word_width)
  ) u_step (
    .rem         (rem),
    .dividend_msb(dividend[word_width-1]),
    .divisor     (divisor),
    .rem_next    (rem_next),
    .q_bit       (q_bit)
  );

  // Quotient is negative when operand signs differ; the remainder follows the
  // dividend's sign so that the quotient truncates toward zero.
  assign neg_q   = sgn_op & (sign_a ^ sign_b);
  assign neg_r   = sgn_op & sign_a;
  assign q_fix   = dz ? '1     : cond_negate(dividend, neg_q);
  assign rem_fix = dz ? a_orig : cond_negate(rem, neg_r);

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      count    <= '0;
      sgn_op   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      dz       <= 1'b0;
      rem      <= '0;
      dividend <= '0;
      divisor  <= '0;
      a_orig   <= '0;
      DONE     <= 1'b0;
      Q        <= '0;
      REM      <= '0;
      DZF      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            sgn_op   <= SIGNED;
            sign_a   <= A[word_width-1];
            sign_b   <= B[word_width-1];
            dividend <= a_mag;
            divisor  <= b_mag;
            a_orig   <= A;
            rem      <= '0;
            count    <= CW'(word_width);
            dz       <= (B == '0);
            // A zero divisor skips the iteration entirely.
            state    <= (B == '0) ? FIX : ITER;
          end
        end
        ITER: begin
          // The dividend register shifts out its MSB into the remainder and
          // collects quotient bits at its LSB, ending up as the quotient.
          rem      <= rem_next;
          dividend <= {dividend[word_width-2:0], q_bit};
          count    <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          Q     <= q_fix;
          REM   <= rem_fix;
          DZF   <= dz;
          DONE  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
module tb_alu_divider;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic         SIGNED = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] Q;
  logic [W-1:0] REM;
  logic         DZF;

  int total = 0;
  int bad   = 0;

  alu_divider #(.word_width(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .SIGNED(SIGNED),
    .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .Q(Q), .REM(REM), .DZF(DZF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain integer division on the operand values.
  function automatic void model_calc(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] q, output logic [W-1:0] r, output logic d);
    int sa, sb;
    if (b == 0) begin
      q = '1; r = a; d = 1'b1;
    end else if (s) begin
      sa = $signed(a); sb = $signed(b);
      q = W'(sa / sb); r = W'(sa % sb); d = 1'b0;
    end else begin
      q = a / b; r = a % b; d = 1'b0;
    end
  endfunction

  // Cycle-level behavioural model: remaining edges until completion.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic         m_d = 1'b0, p_d = 1'b0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_d = 1'b0;
    end else if (m_left == 0) begin
      m_done = 1'b0;
      if (START) begin
        model_calc(SIGNED, A, B, p_q, p_r, p_d);
        m_left = (B == 0) ? 1 : W + 1;
      end
    end else begin
      m_left--;
      m_done = (m_left == 0);
      if (m_done) begin
        m_q = p_q; m_r = p_r; m_d = p_d;
      end
    end
  end

  always @(negedge CLK) begin
    chk("cyc_busy", BUSY, (m_left != 0));
    chk("cyc_done", DONE, m_done);
    chk("cyc_q", Q, m_q);
    chk("cyc_rem", REM, m_r);
    chk("cyc_dzf", DZF, m_d);
  end

  // Waits for DONE, sampling 1 time unit after each rising edge.
  task automatic wait_done(output int edges, inout int busy_cnt, output logic found);
    edges = 0; found = 1'b0;
    while (edges < 40 && !found) begin
      @(posedge CLK); #1;
      edges++;
      if (DONE) found = 1'b1;
      else if (BUSY) busy_cnt++;
    end
  endtask

  task automatic do_op(input string name, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed, input int lat);
    int edges, busy_cnt;
    logic found;
    @(negedge CLK); #1;
    START = 1'b1; SIGNED = s; A = a; B = b;
    @(posedge CLK); #1;
    START = 1'b0; A = W'($urandom); B = W'($urandom); SIGNED = ~s;
    busy_cnt = BUSY ? 1 : 0;
    wait_done(edges, busy_cnt, found);
    chk({name, "_found"}, found, 1'b1);
    chk({name, "_lat"}, edges, lat);
    chk({name, "_busy"}, busy_cnt, lat);
    chk({name, "_q"}, Q, eq);
    chk({name, "_rem"}, REM, er);
    chk({name, "_dzf"}, DZF, ed);
  endtask

  logic [W-1:0] t_a [4] = '{8'd200, 8'hF9, 8'h07, 8'hFF};
  logic [W-1:0] t_b [4] = '{8'd7,   8'h02, 8'hFE, 8'h01};
  logic         t_s [4] = '{1'b0,   1'b1,  1'b1,  1'b0};
  logic [W-1:0] t_q [4] = '{8'h1C,  8'hFD, 8'hFD, 8'hFF};
  logic [W-1:0] t_r [4] = '{8'h04,  8'hFF, 8'h01, 8'h00};

  initial begin
    logic [W-1:0] q, r;
    logic d, found;
    int edges, busy_cnt, done_seen;

    // Pin the arithmetic model with hand-computed values.
    model_calc(1'b0, 8'd200, 8'd7, q, r, d);
    chk("mdl_u_q", q, 8'h1C); chk("mdl_u_r", r, 8'h04);
    model_calc(1'b1, 8'h80, 8'hFF, q, r, d);
    chk("mdl_ovf_q", q, 8'h80); chk("mdl_ovf_r", r, 8'h00);
    model_calc(1'b1, 8'h07, 8'hFE, q, r, d);
    chk("mdl_s_q", q, 8'hFD); chk("mdl_s_r", r, 8'h01);
    model_calc(1'b1, 8'h55, 8'h00, q, r, d);
    chk("mdl_dz_q", q, 8'hFF); chk("mdl_dz_d", d, 1'b1);

    // Reset values
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_busy", BUSY, 1'b0); chk("rst_done", DONE, 1'b0);
    chk("rst_q", Q, 8'h00); chk("rst_rem", REM, 8'h00); chk("rst_dzf", DZF, 1'b0);
    RST_N = 1'b1;

    // Basic unsigned and signed divisions
    do_op("u200_7", 1'b0, 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 9);
    do_op("sm7_2", 1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9);
    do_op("s7_m2", 1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9);

    // Divide by zero, then a valid op clears the flag
    do_op("dz_u", 1'b0, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1);
    do_op("dz_s", 1'b1, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1);
    do_op("after_dz", 1'b0, 8'd9, 8'd3, 8'h03, 8'h00, 1'b0, 9);

    // Overflow and extreme operands
    do_op("min_m1", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
    do_op("ff_1", 1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 9);

    // START while busy is ignored
    @(negedge CLK); #1;
    START = 1'b1; SIGNED = 1'b0; A = 8'd200; B = 8'd7;
    @(posedge CLK); #1; START = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    START = 1'b1; SIGNED = 1'b1; A = 8'd3; B = 8'd1;
    @(posedge CLK); #1; START = 1'b0;
    busy_cnt = 0;
    wait_done(edges, busy_cnt, found);
    chk("ign_found", found, 1'b1);
    chk("ign_lat", edges, 6);
    chk("ign_q", Q, 8'h1C);
    chk("ign_rem", REM, 8'h04);
    done_seen = 0;
    repeat (12) begin @(posedge CLK); #1; if (DONE) done_seen++; end
    chk("ign_no_second", done_seen, 0);

    // Reset in the third ITER cycle
    @(negedge CLK); #1;
    START = 1'b1; SIGNED = 1'b0; A = 8'd200; B = 8'd7;
    @(posedge CLK); #1; START = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_busy", BUSY, 1'b0); chk("mid_rst_done", DONE, 1'b0);
    chk("mid_rst_q", Q, 8'h00); chk("mid_rst_rem", REM, 8'h00); chk("mid_rst_dzf", DZF, 1'b0);
    @(negedge CLK); #1;
    RST_N = 1'b1;
    done_seen = 0;
    repeat (12) begin @(posedge CLK); #1; if (DONE) done_seen++; end
    chk("mid_rst_no_done", done_seen, 0);
    do_op("u100_10", 1'b0, 8'd100, 8'd10, 8'd10, 8'h00, 1'b0, 9);

    // Back-to-back with START held high
    @(negedge CLK); #1;
    START = 1'b1; SIGNED = t_s[0]; A = t_a[0]; B = t_b[0];
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      busy_cnt = 0;
      wait_done(edges, busy_cnt, found);
      chk("b2b_found", found, 1'b1);
      chk("b2b_gap", edges, (i == 0) ? 9 : 10);
      chk("b2b_q", Q, t_q[i]);
      chk("b2b_rem", REM, t_r[i]);
      if (i < 3) begin
        SIGNED = t_s[i+1]; A = t_a[i+1]; B = t_b[i+1];
      end else begin
        START = 1'b0;
      end
    end
    repeat (3) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
